// File: rtl/writeback_scoreboard.sv
// Writeback scoreboard: MEM/WB pipeline register feeding the register file,
// plus per-register pending-write counters that flag read-after-write hazards
// for the instruction sitting in ID. R15 (PC) is never tracked.
module writeback_scoreboard #(
    parameter int NREG = 15,
    parameter int CW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MEM_WB_EN,
    input  logic            MEM_R_EN,
    input  logic [3:0]      MEM_Dest,
    input  logic [31:0]     ALU_Res,
    input  logic [31:0]     Mem_Data,
    input  logic            freeze,
    input  logic            ID_Issue,
    input  logic            ID_WB_EN,
    input  logic [3:0]      ID_Dest,
    input  logic [3:0]      src1,
    input  logic [3:0]      src2,
    input  logic            Two_src,
    output logic [3:0]      WB_Dest,
    output logic [31:0]     WB_Value,
    output logic            WB_WB_EN,
    output logic            hazard,
    output logic [NREG-1:0] pending,
    output logic            sb_err
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [3:0]    PC_IDX  = 4'd15;

    logic                     vld_p1;
    logic [3:0]               dest_p1;
    logic [31:0]              alu_p1;
    logic [31:0]              mem_p1;
    logic                     ld_p1;

    logic [NREG-1:0][CW-1:0]  cnt;
    logic [NREG-1:0][CW-1:0]  cnt_nxt;
    logic [CW:0]              step_r;
    logic                     err_set;
    logic                     issue_ev;
    logic                     retire_ev;
    logic [15:0]              pend_ext;

    // Saturating up/down step of one pending counter; returns {error, next}.
    // Simultaneous issue and retire cancel; an overflow or underflow holds the
    // count and raises the error bit.
    function automatic logic [CW:0] sat_step(input logic [CW-1:0] c,
                                             input logic inc,
                                             input logic dec);
        logic [CW:0] r;
        r = {1'b0, c};
        if (inc && !dec) begin
            if (c == CNT_MAX) r = {1'b1, c};
            else              r = {1'b0, c + 1'b1};
        end else if (dec && !inc) begin
            if (c == '0) r = {1'b1, c};
            else         r = {1'b0, c - 1'b1};
        end
        return r;
    endfunction

    assign issue_ev  = ID_Issue && ID_WB_EN && (ID_Dest != PC_IDX);
    assign retire_ev = vld_p1 && (dest_p1 != PC_IDX);

    // ---- MEM -> WB stage boundary ----
    // MEM/WB capture; a frozen MEM stage inserts a bubble so a held
    // instruction writes back only once, when the freeze releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            dest_p1 <= '0;
            alu_p1  <= '0;
            mem_p1  <= '0;
            ld_p1   <= 1'b0;
        end else if (freeze) begin
            vld_p1  <= 1'b0;
        end else begin
            vld_p1  <= MEM_WB_EN;
            dest_p1 <= MEM_Dest;
            alu_p1  <= ALU_Res;
            mem_p1  <= Mem_Data;
            ld_p1   <= MEM_R_EN;
        end
    end

    assign WB_WB_EN = vld_p1;
    assign WB_Dest  = dest_p1;
    assign WB_Value = ld_p1 ? mem_p1 : alu_p1;

    // Next-state of every pending counter from this cycle's issue and retire.
    always_comb begin
        cnt_nxt = cnt;
        err_set = 1'b0;
        step_r  = '0;
        for (int i = 0; i < NREG; i++) begin
            step_r     = sat_step(cnt[i],
                                  issue_ev  && (ID_Dest == 4'(i)),
                                  retire_ev && (dest_p1 == 4'(i)));
            cnt_nxt[i] = step_r[CW-1:0];
            err_set    = err_set | step_r[CW];
        end
    end

    // Counter state and the sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            sb_err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (err_set) sb_err <= 1'b1;
        end
    end

    // Pending bits, zero-extended to the full 4-bit index space (R15 never pending).
    always_comb begin
        pending  = '0;
        pend_ext = '0;
        for (int i = 0; i < NREG; i++) begin
            pending[i] = |cnt[i];
            if (i < 15) pend_ext[i] = |cnt[i];
        end
    end

    // Hazard uses pre-edge counter state; no bypass of a same-cycle retire.
    assign hazard = ((src1 != PC_IDX) && pend_ext[src1]) ||
                    (Two_src && (src2 != PC_IDX) && pend_ext[src2]);

endmodule
